serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor computing `a - b - bin`, one bit per clock, LSB first. Each bit uses a single full-subtractor cell and a borrow flip-flop. It is the subtracting counterpart of the team's ripple full-adder datapath, built for area-constrained arithmetic where a `WIDTH`-cycle latency is acceptable. A start/busy/done handshake connects it to a controlling FSM.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request; sampled only in IDLE or DONE.
- `a`  in  WIDTH: minuend; captured on an accepted `start`.
- `b`  in  WIDTH: subtrahend; captured on an accepted `start`.
- `bin`  in  1: borrow-in; captured on an accepted `start`.
- `busy`  out  1: high while the state is RUN.
- `done`  out  1: one-cycle pulse; result valid.
- `diff`  out  WIDTH: result `(a - b - bin) mod 2^WIDTH`.
- `borrow`  out  1: borrow-out; 1 when `a < b + bin` (unsigned).

## Operation

- FSM states are IDLE, RUN and DONE.
- Reset values:
  - state = IDLE.
  - `busy` = 0, `done` = 0, `diff` = 0, `borrow` = 0.
  - Internal operand shift registers, result shift register, borrow flip-flop and bit counter are all 0.
- IDLE:
  - With `start` = 1, capture `a`, `b`, set borrow flip-flop `br` = `bin`, counter = 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Let `x` = `a_sr[0]`, `y` = `b_sr[0]`.
  - Difference bit `d` = `x ^ y ^ br`.
  - `br_next` = `(~x & y) | (~(x ^ y) & br)`.
  - Shift `a_sr` and `b_sr` right by 1.
  - Shift the result register right by 1 with `d` into the MSB.
  - Increment the counter.
- RUN exit: when the counter reaches `WIDTH-1` and that bit is processed:
  - Load `diff` with the completed result register (including that final bit).
  - Load `borrow` with `br_next`.
  - Go to DONE.
- `start` while in RUN is ignored; captured operands are unaffected.
- DONE:
  - `done` = 1 for exactly this one cycle.
  - With `start` = 1, accept a new operation exactly as in IDLE (go to RUN).
  - Otherwise go to IDLE.
- `diff` and `borrow` change only on entry to DONE. They hold their value through IDLE and the next RUN until the next DONE.
- Counter width is `$clog2(WIDTH)`. The counter never wraps during RUN.
- Reset asserted mid-operation: immediate return to reset values. The in-flight result is discarded and no `done` is produced.

## Timing

- `start` is sampled at the rising edge ending cycle 0.
  - `busy` = 1 in cycles 1..WIDTH.
  - `done` = 1 and the new `diff`/`borrow` are valid in cycle WIDTH+1.
  - Latency from accepted start to done is WIDTH+1 cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles, achieved by asserting `start` in the DONE cycle.
- `busy` and `done` are never both high.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `a`, `b` and `bin` may change freely after the accepting edge.

## Test plan

All scenarios use `WIDTH` = 8.
- Basic subtract: `a`=0x5A, `b`=0x3C, `bin`=0 -> `diff`=0x1E, `borrow`=0. `done` appears exactly 9 cycles after the start edge, and `busy` is high for 8 cycles.
- Underflow and borrow-in:
  - `a`=0x00, `b`=0x01, `bin`=0 -> `diff`=0xFF, `borrow`=1.
  - `a`=0x80, `b`=0x7F, `bin`=1 -> `diff`=0x00, `borrow`=0.
  - `a`=`b`=0xA5, `bin`=1 -> `diff`=0xFF, `borrow`=1.
- Start while busy: issue 0x10-0x01, then pulse `start` with `a`=0xFF, `b`=0 in cycle 4 -> result 0x0F, `borrow`=0, exactly one `done`. The second request is ignored.
- Back-to-back: `start` held high continuously with new operands presented in each DONE cycle (0x20-0x10, then 0x03-0x05) -> results 0x10 (`borrow`=0) and 0xFE (`borrow`=1). The two `done` pulses are 9 cycles apart, and IDLE is never visited between them.
- Reset mid-operation: assert `rst` in cycle 5 of a RUN -> all outputs read 0 asynchronously and no `done` is produced. After release, 0x09-0x04 gives 0x05 normally.
- Randomized check: 1000 random `a`/`b`/`bin` values compared against the `{borrow, diff} = a - b - bin` reference model, with the result checked held stable until the next DONE.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, one full-subtractor cell, LSB first, WIDTH+1 cycle latency.
// start/busy/done handshake; diff and borrow are registered and held until the next result.
`timescale 1ns/1ps
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CntW-1:0]  cnt;

  logic             x;
  logic             y;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] a_shift;

  // Full-subtractor cell; the minuend register doubles as the result register,
  // so difference bits enter at the MSB as minuend bits leave at the LSB.
  always_comb begin
    x       = a_sr[0];
    y       = b_sr[0];
    d       = x ^ y ^ br;
    br_next = (~x & y) | (~(x ^ y) & br);
    a_shift = {d, a_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= StIdle;
      a_sr   <= '0;
      b_sr   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle, StDone: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end else begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        StRun: begin
          a_sr <= a_shift;
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          br   <= br_next;
          if (cnt == LastBit) begin
            diff   <= a_shift;
            borrow <= br_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed scenarios plus 1000 random
// operations checked against an integer-arithmetic reference.
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_diff = '0;
  logic         prev_borrow = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, wrapped to W bits, borrow = result negative.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       output logic [W-1:0] ed, output logic eb);
    int r;
    r  = int'(ta) - int'(tb_v) - int'(tbin);
    ed = r[W-1:0];
    eb = (r < 0);
  endtask

  // Called at a negedge; returns at the negedge inside the DONE cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input string tag);
    logic [W-1:0] ed;
    logic         eb;
    model(ta, tb_v, tbin, ed, eb);
    start = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(posedge clk);
    #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int k = 1; k <= int'(W); k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
      if (k == 4) begin
        chk({tag, "_hold_diff"}, diff, prev_diff);
        chk({tag, "_hold_borrow"}, borrow, prev_borrow);
      end
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
    prev_diff   = ed;
    prev_borrow = eb;
  endtask

  initial begin
    int ndone;
    int dcyc;
    int dcyc2;
    bit idle_seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_borrow", borrow, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h5A, 8'h3C, 1'b0, "basic");
    @(negedge clk);
    chk("basic_done_pulse", done, 0);
    run_op(8'h00, 8'h01, 1'b0, "underflow");
    run_op(8'h80, 8'h7F, 1'b1, "bin_zero");
    run_op(8'hA5, 8'hA5, 1'b1, "equal_bin");
    @(negedge clk);

    // Start pulse in cycle 4 of a run must be ignored.
    ndone = 0; dcyc = 0;
    start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        dcyc = k;
      end
      if (k == 9) begin
        chk("sbusy_diff", diff, 8'h0F);
        chk("sbusy_borrow", borrow, 0);
      end
    end
    chk("sbusy_ndone", ndone, 1);
    chk("sbusy_dcyc", dcyc, 9);
    prev_diff = 8'h0F; prev_borrow = 1'b0;

    // Back-to-back with start held high.
    ndone = 0; dcyc = 0; dcyc2 = 0; idle_seen = 1'b0;
    start = 1'b1; a = 8'h20; b = 8'h10; bin = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (dcyc == 0) dcyc = k; else dcyc2 = k;
      end
      if (k >= 10 && k <= 17 && !busy) idle_seen = 1'b1;
      if (k == 9) begin
        chk("b2b_diff0", diff, 8'h10);
        chk("b2b_borrow0", borrow, 0);
        a = 8'h03; b = 8'h05;
      end
      if (k == 18) begin
        chk("b2b_diff1", diff, 8'hFE);
        chk("b2b_borrow1", borrow, 1);
        start = 1'b0;
      end
    end
    chk("b2b_ndone", ndone, 2);
    chk("b2b_spacing", dcyc2 - dcyc, 9);
    chk("b2b_no_idle", idle_seen, 0);
    @(negedge clk);

    // Reset mid-operation clears outputs without a clock edge and suppresses done.
    start = 1'b1; a = 8'h77; b = 8'h11; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_diff", diff, 0);
    chk("mrst_borrow", borrow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mrst_nodone", ndone, 0);
    prev_diff = '0; prev_borrow = 1'b0;
    run_op(8'h09, 8'h04, 1'b0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      run_op(ra, rb, rbin, "rand");
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rand_idle_diff", diff, prev_diff);
        chk("rand_idle_borrow", borrow, prev_borrow);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
